// File: rtl/lbdr_pkg.sv
// Shared types and helpers for the LBDR routing unit.
// Optional feature macro used by this slice: LBDR_FORK_EN.
package lbdr_pkg;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    typedef enum logic [2:0] {
        P_N = 3'd0,
        P_E = 3'd1,
        P_W = 3'd2,
        P_S = 3'd3,
        P_L = 3'd4
    } port_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ROUTED = 1'b1
    } state_t;

    // Keep only the lowest set bit: N > E > W > S priority by port index.
    function automatic logic [3:0] prio_onehot(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/lbdr_dr_unit_if.sv
// Flit-side handshake and route/error outputs of the LBDR routing unit.
interface lbdr_dr_unit_if #(parameter int COORD_W = 2);

    logic                   empty;
    logic [2:0]             flit_id;
    logic [2*COORD_W-1:0]   dst_addr;
    logic                   flit_rd;
    logic [4:0]             port_req;
    logic                   route_valid;
    logic                   cfg_busy;
    logic                   err_orphan;
    logic                   err_no_tail;
    logic                   err_unroutable;

    // Routing unit side
    modport slave (
        input  empty, flit_id, dst_addr, flit_rd,
        output port_req, route_valid, cfg_busy,
               err_orphan, err_no_tail, err_unroutable
    );

    // FIFO / allocator side
    modport master (
        output empty, flit_id, dst_addr, flit_rd,
        input  port_req, route_valid, cfg_busy,
               err_orphan, err_no_tail, err_unroutable
    );

endinterface

// File: rtl/lbdr_route_comb.sv
// Combinational LBDR route computation: comparators, minimal candidates,
// fork/priority reduction, deroute fallback and unroutable flag.
// Multi-hot forking is compiled in only with LBDR_FORK_EN.
module lbdr_route_comb
    import lbdr_pkg::*;
#(
    parameter int COORD_W = 2
) (
    input  logic [7:0]           rxy,
    input  logic [3:0]           cx,
    input  logic [7:0]           drt,
    input  logic [3:0]           fork_en,
    input  logic [2*COORD_W-1:0] cur_addr,
    input  logic [2*COORD_W-1:0] dst_addr,
    output logic [4:0]           route,
    output logic                 unroutable
);

    logic [COORD_W-1:0] xc, yc, xd, yd;
    logic               n1, s1, e1, w1, loc;
    logic [3:0]         min_c, pick;
    logic [1:0]         prim, code;

    assign xc = cur_addr[COORD_W-1:0];
    assign yc = cur_addr[2*COORD_W-1:COORD_W];
    assign xd = dst_addr[COORD_W-1:0];
    assign yd = dst_addr[2*COORD_W-1:COORD_W];

    assign n1  = yd < yc;
    assign s1  = yc < yd;
    assign e1  = xc < xd;
    assign w1  = xd < xc;
    assign loc = ~(n1 | s1 | e1 | w1);

`ifndef LBDR_FORK_EN
    logic unused_fork;
    assign unused_fork = ^fork_en;
`endif

    // Minimal candidates, reduction, then deroute if nothing minimal survives.
    always_comb begin
        min_c      = '0;
        route      = '0;
        unroutable = 1'b0;
        // rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
        min_c[P_N] = cx[P_N] & ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1]));
        min_c[P_E] = cx[P_E] & ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3]));
        min_c[P_W] = cx[P_W] & ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5]));
        min_c[P_S] = cx[P_S] & ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7]));

        pick = prio_onehot(min_c);
`ifdef LBDR_FORK_EN
        // Fork candidates win as a group; priority only applies when none exist.
        if (|(min_c & fork_en))
            pick = min_c & fork_en;
`endif

        // Primary direction for deroute: first of N, E, W, S that is true.
        if (n1)      prim = 2'd0;
        else if (e1) prim = 2'd1;
        else if (w1) prim = 2'd2;
        else         prim = 2'd3;
        code = drt[{prim, 1'b0} +: 2];

        if (loc) begin
            route[P_L] = 1'b1;
        end else if (|pick) begin
            route[3:0] = pick;
        end else begin
            route[code] = cx[code];
            unroutable  = ~cx[code];
        end
    end

endmodule

// File: rtl/lbdr_dr_unit.sv
// LBDR routing unit for one mesh input port: config registers, packet
// state machine holding the route from HEADER to TAIL, registered outputs.
// Optional feature macro: LBDR_FORK_EN (multi-hot forking in lbdr_route_comb).
module lbdr_dr_unit
    import lbdr_pkg::*;
#(
    parameter int COORD_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           cfg_rxy,
    input  logic [3:0]           cfg_cx,
    input  logic [7:0]           cfg_drt,
    input  logic [3:0]           cfg_fork,
    input  logic [2*COORD_W-1:0] cfg_cur_addr,
    input  logic                 cfg_we,
    lbdr_dr_unit_if.slave        bus
);

    state_t               state_q, state_d;
    logic [7:0]           rxy_q, rxy_d;
    logic [3:0]           cx_q, cx_d;
    logic [7:0]           drt_q, drt_d;
    logic [3:0]           fork_q, fork_d;
    logic [2*COORD_W-1:0] cur_q, cur_d;
    logic [4:0]           req_q, req_d;
    logic                 vld_q, vld_d;
    logic                 orphan_q, orphan_d;
    logic                 notail_q, notail_d;
    logic                 unr_q, unr_d;

    logic [4:0]           route;
    logic                 unroutable;
    logic                 pop;

    lbdr_route_comb #(.COORD_W(COORD_W)) u_route (
        .rxy        (rxy_q),
        .cx         (cx_q),
        .drt        (drt_q),
        .fork_en    (fork_q),
        .cur_addr   (cur_q),
        .dst_addr   (bus.dst_addr),
        .route      (route),
        .unroutable (unroutable)
    );

    // A pop only counts when the FIFO actually holds a flit.
    assign pop = bus.flit_rd & ~bus.empty;

    // Config writes land only while no packet owns the route.
    always_comb begin
        rxy_d  = rxy_q;
        cx_d   = cx_q;
        drt_d  = drt_q;
        fork_d = fork_q;
        cur_d  = cur_q;
        if (cfg_we && state_q == IDLE) begin
            rxy_d  = cfg_rxy;
            cx_d   = cfg_cx;
            drt_d  = cfg_drt;
            fork_d = cfg_fork;
            cur_d  = cfg_cur_addr;
        end
    end

    // Packet FSM next state, route register and error pulses.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        vld_d    = vld_q;
        orphan_d = 1'b0;
        notail_d = 1'b0;
        unr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.empty) begin
                    if (bus.flit_id == FLIT_HEADER) begin
                        // Unroutable HEADER stays at head and is retried each cycle.
                        if (unroutable) begin
                            unr_d = 1'b1;
                        end else begin
                            req_d   = route;
                            vld_d   = 1'b1;
                            state_d = ROUTED;
                        end
                    end else if (bus.flit_id == FLIT_BODY || bus.flit_id == FLIT_TAIL) begin
                        orphan_d = 1'b1;
                    end
                end
            end
            ROUTED: begin
                if (pop && bus.flit_id == FLIT_TAIL) begin
                    req_d   = '0;
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end else if (pop && bus.flit_id == FLIT_HEADER) begin
                    // Missing TAIL: adopt the new packet's route straight away.
                    notail_d = 1'b1;
                    if (unroutable) begin
                        unr_d   = 1'b1;
                        req_d   = '0;
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        req_d = route;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State, config and output registers; reset reloads config from the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            vld_q    <= 1'b0;
            orphan_q <= 1'b0;
            notail_q <= 1'b0;
            unr_q    <= 1'b0;
            rxy_q    <= cfg_rxy;
            cx_q     <= cfg_cx;
            drt_q    <= cfg_drt;
            fork_q   <= cfg_fork;
            cur_q    <= cfg_cur_addr;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            vld_q    <= vld_d;
            orphan_q <= orphan_d;
            notail_q <= notail_d;
            unr_q    <= unr_d;
            rxy_q    <= rxy_d;
            cx_q     <= cx_d;
            drt_q    <= drt_d;
            fork_q   <= fork_d;
            cur_q    <= cur_d;
        end
    end

    assign bus.port_req       = req_q;
    assign bus.route_valid    = vld_q;
    assign bus.cfg_busy       = (state_q == ROUTED);
    assign bus.err_orphan     = orphan_q;
    assign bus.err_no_tail    = notail_q;
    assign bus.err_unroutable = unr_q;

endmodule
